masked_stream_eq_checker: RTL and testbench

Parametrised, clocked successor to the 1-bit equality detector. Compares two WIDTH-bit word streams beat-by-beat over a programmed frame length under a per-bit compare mask. Accumulates a mismatch count and the index of the first mismatching beat, then reports frame pass/fail. Sits between a data source under test and a golden-model stream in self-checking datapaths and benches.

---
 rtl/masked_stream_eq_pkg.sv | 14 +
 rtl/eq_cmp_masked.sv | 20 ++
 rtl/masked_stream_eq_checker.sv | 118 +++++++++++
 tb/tb_masked_stream_eq_checker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/masked_stream_eq_pkg.sv
// masked_stream_eq_pkg: shared FSM state type and counter saturation helper
package masked_stream_eq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [31:0] sat_max(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/eq_cmp_masked.sv
// eq_cmp_masked: flags any differing bit between a and b among the bits enabled by mask
module eq_cmp_masked #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] mask,
    output logic             mismatch
);

    logic [WIDTH-1:0] diff;

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_bit
        assign diff[i] = (a[i] ^ b[i]) & mask[i];
    end

    assign mismatch = |diff;

endmodule

// File: rtl/masked_stream_eq_checker.sv
// masked_stream_eq_checker: masked beat-by-beat comparison of two word streams over a programmed frame
module masked_stream_eq_checker
    import masked_stream_eq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] mask,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [LEN_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [LEN_W-1:0] first_err_idx
);

    localparam logic [LEN_W-1:0] ERR_SAT = LEN_W'(sat_max(LEN_W));

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] err_q, err_d;
    logic [LEN_W-1:0] fei_q, fei_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             fev_q, fev_d;
    logic             pass_q, pass_d;
    logic             mismatch;

    eq_cmp_masked #(.WIDTH(WIDTH)) u_cmp (
        .a        (a),
        .b        (b),
        .mask     (mask_q),
        .mismatch (mismatch)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        err_d   = err_q;
        fei_d   = fei_q;
        mask_d  = mask_q;
        fev_d   = fev_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    mask_d  = mask;
                    idx_d   = '0;
                    err_d   = '0;
                    fei_d   = '0;
                    fev_d   = 1'b0;
                    pass_d  = (len == '0);
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (mismatch) begin
                        err_d = (err_q == ERR_SAT) ? err_q : err_q + LEN_W'(1);
                        if (!fev_q) begin
                            fev_d = 1'b1;
                            fei_d = idx_q;
                        end
                    end
                    idx_d = idx_q + LEN_W'(1);
                    // pass is registered on entry to DONE so it is already valid while done pulses
                    if (idx_q == len_q - LEN_W'(1)) begin
                        state_d = DONE;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            fei_q   <= '0;
            mask_q  <= '0;
            fev_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fei_q   <= fei_d;
            mask_q  <= mask_d;
            fev_q   <= fev_d;
            pass_q  <= pass_d;
        end
    end

    assign in_ready        = (state_q == RUN);
    assign busy            = (state_q == RUN) || (state_q == DONE);
    assign done            = (state_q == DONE);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_masked_stream_eq_checker.sv
// tb_masked_stream_eq_checker: directed and random frames checked against a frame-level reference model
module tb_masked_stream_eq_checker;

    localparam int WIDTH = 8;
    localparam int LEN_W = 3;

    logic             clk = 1'b0;
    logic             rst, start, in_valid;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] mask, a, b;
    logic             in_ready, busy, done, pass, first_err_valid;
    logic [LEN_W-1:0] err_count, first_err_idx;

    int vectors = 0;
    int miscompares = 0;
    logic [WIDTH-1:0] aa [8];
    logic [WIDTH-1:0] bb [8];

    always #5 clk = ~clk;

    masked_stream_eq_checker #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .len             (len),
        .mask            (mask),
        .in_valid        (in_valid),
        .a               (a),
        .b               (b),
        .in_ready        (in_ready),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_idx   (first_err_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " in_ready"}, 32'(in_ready), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " pass"}, 32'(pass), 0);
        check({tag, " err_count"}, 32'(err_count), 0);
        check({tag, " first_err_valid"}, 32'(first_err_valid), 0);
        check({tag, " first_err_idx"}, 32'(first_err_idx), 0);
    endtask

    // vmode: 0 continuous valid, 1 alternating 1,0,1.., 2 random; poke pulses start (len=1) during RUN
    task automatic frame(input string tag, input int n, input logic [WIDTH-1:0] m,
                         input int vmode, input bit poke);
        int cnt = 0;
        int fidx = -1;
        int beat = 0;
        int edges = 0;
        int sat = (1 << LEN_W) - 1;
        bit phase = 1'b0;
        bit v;
        for (int i = 0; i < n; i++)
            if (((aa[i] ^ bb[i]) & m) != 0) begin
                if (fidx < 0) fidx = i;
                cnt++;
            end
        if (cnt > sat) cnt = sat;
        start = 1'b1;
        len = n[LEN_W-1:0];
        mask = m;
        in_valid = 1'b0;
        tick();
        edges = 1;
        start = 1'b0;
        while (beat < n && edges < 200) begin
            check({tag, " in_ready during frame"}, 32'(in_ready), 1);
            v = (vmode == 0) || (vmode == 1 && !phase) || (vmode == 2 && $urandom_range(0, 2) != 0);
            phase = ~phase;
            in_valid = v;
            if (v) begin
                a = aa[beat];
                b = bb[beat];
            end else begin
                a = WIDTH'($urandom);
                b = ~a;
            end
            start = poke;
            len = LEN_W'(1);
            tick();
            edges++;
            if (v) beat++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check({tag, " done at frame end"}, 32'(done), 1);
        check({tag, " busy in DONE"}, 32'(busy), 1);
        check({tag, " in_ready in DONE"}, 32'(in_ready), 0);
        check({tag, " pass"}, 32'(pass), 32'(cnt == 0));
        check({tag, " err_count"}, 32'(err_count), cnt);
        check({tag, " first_err_valid"}, 32'(first_err_valid), 32'(cnt != 0));
        check({tag, " first_err_idx"}, 32'(first_err_idx), (fidx < 0) ? 0 : fidx);
        tick();
        check({tag, " done pulse width"}, 32'(done), 0);
        check({tag, " busy after done"}, 32'(busy), 0);
        check({tag, " pass held"}, 32'(pass), 32'(cnt == 0));
        check({tag, " err_count held"}, 32'(err_count), cnt);
    endtask

    initial begin
        int n;
        logic [WIDTH-1:0] m;
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        mask = '0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        repeat (2) tick();
        check_idle_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            aa[i] = WIDTH'($urandom);
            bb[i] = aa[i];
        end
        frame("all_match_len4", 4, 8'hFF, 0, 0);

        for (int i = 0; i < 8; i++) begin
            aa[i] = WIDTH'($urandom);
            bb[i] = aa[i];
        end
        aa[1] = 8'h5A; bb[1] = 8'h5B;
        aa[3] = 8'h5A; bb[3] = 8'h5B;
        frame("two_errs_len5", 5, 8'hFF, 0, 0);

        for (int i = 0; i < 8; i++) begin
            aa[i] = 8'h3C;
            bb[i] = 8'h3F;
        end
        frame("masked_nibble_len3", 3, 8'hF0, 0, 0);

        frame("empty_frame", 0, 8'hFF, 0, 0);

        for (int i = 0; i < 8; i++) begin
            aa[i] = WIDTH'($urandom);
            bb[i] = ($urandom_range(0, 1) == 1) ? aa[i] : ~aa[i];
        end
        frame("start_ignored_in_run", 4, 8'hFF, 0, 1);

        for (int i = 0; i < 8; i++) begin
            aa[i] = WIDTH'($urandom);
            bb[i] = aa[i] ^ (8'h01 << $urandom_range(0, 7));
        end
        frame("all_err_stalls_len7", 7, 8'hFF, 1, 0);

        for (int i = 0; i < 8; i++) begin
            aa[i] = WIDTH'($urandom);
            bb[i] = ~aa[i];
        end
        start = 1'b1;
        len = LEN_W'(6);
        mask = 8'hFF;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a = aa[i];
            b = bb[i];
            tick();
        end
        check("pre_reset err_count", 32'(err_count), 2);
        rst = 1'b1;
        a = aa[2];
        b = bb[2];
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check_idle_zero("mid_frame_reset");
        tick();
        check("post_reset stays idle", 32'(in_ready), 0);
        for (int i = 0; i < 8; i++) begin
            aa[i] = WIDTH'($urandom);
            bb[i] = aa[i];
        end
        frame("after_reset_len2", 2, 8'hFF, 0, 0);

        for (int i = 0; i < 8; i++) begin
            aa[i] = WIDTH'($urandom);
            bb[i] = ~aa[i];
        end
        frame("zero_mask", 5, 8'h00, 2, 0);

        repeat (20) begin
            n = $urandom_range(0, 7);
            m = WIDTH'($urandom);
            for (int i = 0; i < 8; i++) begin
                aa[i] = WIDTH'($urandom);
                bb[i] = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom) : aa[i];
            end
            frame("random", n, m, 2, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
